// File: rtl/inst_seq_pkg.sv
// Shared definitions for the instruction sequencer: sizes, halt word,
// instruction field widths and the sequencer state encoding.
package inst_seq_pkg;

    localparam int CNT_INST_MAX = 256;
    localparam int ADDR_W       = 8;
    localparam int INST_W       = 12;
    localparam int OPCODE_W     = 4;
    localparam int OPERAND_W    = INST_W - OPCODE_W;

    localparam logic [INST_W-1:0] HALT_CODE_DEF = 12'hFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/inst_seq.sv
// Instruction sequencer: walks instmem from address 0, hands each word to the
// decoder with a valid/ready handshake, and stops on the halt word, the last address or abort.
module inst_seq
    import inst_seq_pkg::*;
#(
    parameter int                INST_DEPTH = CNT_INST_MAX,
    parameter logic [INST_W-1:0] HALT_CODE  = HALT_CODE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [INST_W-1:0] mem_inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(INST_DEPTH - 1);

    seq_state_t        state;
    logic [ADDR_W-1:0] pc;

    assign mem_addr = pc;

    // All outputs are registered and updated together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            inst_out   <= '0;
            inst_valid <= 1'b0;
            mem_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        mem_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    mem_en <= 1'b0;
                    if (abort || mem_inst == HALT_CODE) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state      <= S_ISSUE;
                        inst_out   <= mem_inst;
                        inst_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // abort together with ready still counts as a completed transfer
                    if (abort || (inst_ready && pc == LAST_PC)) begin
                        state      <= S_DONE;
                        inst_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else if (inst_ready) begin
                        state      <= S_FETCH;
                        pc         <= pc + 1'b1;
                        inst_valid <= 1'b0;
                        mem_en     <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    pc    <= '0;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
